// File: rtl/rsa_seq_ctrl.sv
// Sequencer for one systolic-array matrix product: operand load, pipeline wait, result drain.
// Optional macro RSA_SEQ_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module rsa_seq_ctrl #(
  parameter int X          = 3,
  parameter int N          = 4,
  parameter int Y          = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
`ifdef RSA_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  out_ready,
  output logic                  Xin_val,
  output logic [X-1:0]          x_row_sel,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic                  Yin_val,
  output logic [Y-1:0]          y_col_sel,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  out_val,
  output logic [X-1:0]          out_row_sel,
  output logic [Y-1:0]          out_col_sel,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_t;

  localparam int                    LOAD_LEN = ((X > Y) ? X : Y) * N;
  localparam logic [CNT_W-1:0]      L_CYC    = CNT_W'(LOAD_LEN);
  localparam logic [CNT_W-1:0]      C_CYC    = CNT_W'(X + Y + N - 2);
  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(N - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    xval_q, xval_d, yval_q, yval_d;
  logic [X-1:0]            xsel_q, xsel_d;
  logic [Y-1:0]            ysel_q, ysel_d;
  logic [ADDR_WIDTH-1:0]   xaddr_q, xaddr_d, yaddr_q, yaddr_d;
  logic                    oval_q, oval_d;
  logic [X-1:0]            orow_q, orow_d;
  logic [Y-1:0]            ocol_q, ocol_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    abort_w;

`ifdef RSA_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xval_d  = xval_q;
    xsel_d  = xsel_q;
    xaddr_d = xaddr_q;
    yval_d  = yval_q;
    ysel_d  = ysel_q;
    yaddr_d = yaddr_q;
    oval_d  = oval_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(1);
          xval_d  = 1'b1;
          xsel_d  = X'(1);
          xaddr_d = '0;
          yval_d  = 1'b1;
          ysel_d  = Y'(1);
          yaddr_d = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == L_CYC) begin
          state_d = CALC;
          cnt_d   = CNT_W'(1);
          xval_d  = 1'b0;
          xsel_d  = '0;
          xaddr_d = '0;
          yval_d  = 1'b0;
          ysel_d  = '0;
          yaddr_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Each stream walks k within a row/column, rotating the select on the k wrap.
          if (xval_q) begin
            if (xaddr_q != K_LAST) begin
              xaddr_d = xaddr_q + ADDR_WIDTH'(1);
            end else if (xsel_q[X-1]) begin
              xval_d  = 1'b0;
              xsel_d  = '0;
              xaddr_d = '0;
            end else begin
              xsel_d  = xsel_q << 1;
              xaddr_d = '0;
            end
          end
          if (yval_q) begin
            if (yaddr_q != K_LAST) begin
              yaddr_d = yaddr_q + ADDR_WIDTH'(1);
            end else if (ysel_q[Y-1]) begin
              yval_d  = 1'b0;
              ysel_d  = '0;
              yaddr_d = '0;
            end else begin
              ysel_d  = ysel_q << 1;
              yaddr_d = '0;
            end
          end
        end
      end
      CALC: begin
        if (cnt_q == C_CYC) begin
          state_d = DRAIN;
          cnt_d   = '0;
          oval_d  = 1'b1;
          orow_d  = X'(1);
          ocol_d  = Y'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (!ocol_q[Y-1]) begin
            ocol_d = ocol_q << 1;
          end else if (!orow_q[X-1]) begin
            ocol_d = Y'(1);
            orow_d = orow_q << 1;
          end else begin
            state_d = DONE;
            oval_d  = 1'b0;
            orow_d  = '0;
            ocol_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (abort_w) begin
      state_d = IDLE;
      cnt_d   = '0;
      xval_d  = 1'b0;
      xsel_d  = '0;
      xaddr_d = '0;
      yval_d  = 1'b0;
      ysel_d  = '0;
      yaddr_d = '0;
      oval_d  = 1'b0;
      orow_d  = '0;
      ocol_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xval_q  <= 1'b0;
      xsel_q  <= '0;
      xaddr_q <= '0;
      yval_q  <= 1'b0;
      ysel_q  <= '0;
      yaddr_q <= '0;
      oval_q  <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xval_q  <= xval_d;
      xsel_q  <= xsel_d;
      xaddr_q <= xaddr_d;
      yval_q  <= yval_d;
      ysel_q  <= ysel_d;
      yaddr_q <= yaddr_d;
      oval_q  <= oval_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Xin_val     = xval_q;
  assign x_row_sel   = xsel_q;
  assign x_addr      = xaddr_q;
  assign Yin_val     = yval_q;
  assign y_col_sel   = ysel_q;
  assign y_addr      = yaddr_q;
  assign out_val     = oval_q;
  assign out_row_sel = orow_q;
  assign out_col_sel = ocol_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Scoreboard bench for rsa_seq_ctrl: a 3x3 instance and a 3x2 instance, directed schedules.
module tb_rsa_seq_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start1, out_ready;
`ifdef RSA_SEQ_ABORT_EN
  logic abort;
`endif

  logic       xv0, yv0, ov0, busy0, done0;
  logic [2:0] xs0, ys0, or0, oc0;
  logic [1:0] xa0, ya0;
  logic       xv1, yv1, ov1, busy1, done1;
  logic [2:0] xs1, or1;
  logic [1:0] ys1, oc1;
  logic [1:0] xa1, ya1;

  rsa_seq_ctrl dut0 (
    .clk(clk), .sys_rst(rst), .start(start),
`ifdef RSA_SEQ_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready),
    .Xin_val(xv0), .x_row_sel(xs0), .x_addr(xa0),
    .Yin_val(yv0), .y_col_sel(ys0), .y_addr(ya0),
    .out_val(ov0), .out_row_sel(or0), .out_col_sel(oc0),
    .busy(busy0), .done(done0)
  );

  rsa_seq_ctrl #(.Y(2)) dut1 (
    .clk(clk), .sys_rst(rst), .start(start1),
`ifdef RSA_SEQ_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready),
    .Xin_val(xv1), .x_row_sel(xs1), .x_addr(xa1),
    .Yin_val(yv1), .y_col_sel(ys1), .y_addr(ya1),
    .out_val(ov1), .out_row_sel(or1), .out_col_sel(oc1),
    .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        xv;
    logic [3:0]  xs;
    logic [1:0]  xa;
    logic        yv;
    logic [3:0]  ys;
    logic [1:0]  ya;
    logic        ov;
    logic [3:0]  orow;
    logic [3:0]  ocol;
    logic        done;
    logic        busy;
  } rec_t;

  rec_t q [2][$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic end_req  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input rec_t r);
    return $sformatf("cyc=%0d xv=%b xs=%b xa=%0d yv=%b ys=%b ya=%0d ov=%b row=%b col=%b done=%b busy=%b",
                     r.cyc, r.xv, r.xs, r.xa, r.yv, r.ys, r.ya, r.ov, r.orow, r.ocol, r.done, r.busy);
  endfunction

  // Expected per-cycle outputs from hand-computed phase boundaries (cycle 0 = start cycle).
  task automatic push_run(input int id, input int t0, input int ny, input int x_end, input int y_end,
                          input int d_start, input int t_done, input int stall_k, input int stall_len,
                          input int cutoff);
    rec_t r;
    int   k, hold;
    k = 0;
    hold = 0;
    for (int t = 1; t <= t_done + 1; t++) begin
      r = '0;
      r.cyc  = 32'(t0 + t);
      r.busy = (t <= t_done);
      if (t <= x_end) begin
        r.xv = 1'b1; r.xs = 4'(1 << ((t - 1) / N)); r.xa = 2'((t - 1) % N);
      end
      if (t <= y_end) begin
        r.yv = 1'b1; r.ys = 4'(1 << ((t - 1) / N)); r.ya = 2'((t - 1) % N);
      end
      if (t >= d_start && t < t_done) begin
        r.ov = 1'b1; r.orow = 4'(1 << (k / ny)); r.ocol = 4'(1 << (k % ny));
        if (k == stall_k && hold < stall_len) hold++;
        else k++;
      end
      r.done = (t == t_done);
      if (t <= cutoff) q[id].push_back(r);
    end
  endtask

  task automatic push_zero(input int id, input int c);
    rec_t r;
    r = '0;
    r.cyc = 32'(c);
    q[id].push_back(r);
  endtask

  task automatic scb(input int id, input rec_t a);
    rec_t e;
    while (q[id].size() > 0 && q[id][0].cyc < a.cyc) begin
      e = q[id].pop_front();
      n_checks++; n_fail++;
      $display("FAIL missed_cycle dut%0d: now %0d, required %s", id, a.cyc, fmt(e));
    end
    if (q[id].size() > 0 && q[id][0].cyc == a.cyc) begin
      e = q[id].pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs dut%0d: got %s required %s", id, fmt(a), fmt(e));
      end
    end else if (a.xv | a.yv | a.ov | a.done | a.busy) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected dut%0d: got %s required idle", id, fmt(a));
    end
  endtask

  initial begin : monitor
    rec_t a0, a1;
    forever begin
      @(negedge clk);
      a0 = '0; a1 = '0;
      a0.cyc = 32'(cyc); a0.xv = xv0; a0.xs = 4'(xs0); a0.xa = xa0; a0.yv = yv0; a0.ys = 4'(ys0);
      a0.ya = ya0; a0.ov = ov0; a0.orow = 4'(or0); a0.ocol = 4'(oc0); a0.done = done0; a0.busy = busy0;
      a1.cyc = 32'(cyc); a1.xv = xv1; a1.xs = 4'(xs1); a1.xa = xa1; a1.yv = yv1; a1.ys = 4'(ys1);
      a1.ya = ya1; a1.ov = ov1; a1.orow = 4'(or1); a1.ocol = 4'(oc1); a1.done = done1; a1.busy = busy1;
      scb(0, a0);
      scb(1, a1);
      if (end_req) begin
        for (int i = 0; i < 2; i++) begin
          n_checks++;
          if (q[i].size() != 0) begin
            n_fail++;
            $display("FAIL leftover dut%0d: got %0d pending records required 0", i, q[i].size());
          end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain_wait();
    int g;
    g = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && g < 400) begin
      tick();
      g++;
    end
    repeat (3) tick();
  endtask

  initial begin : stimulus
    int base;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b1;
`ifdef RSA_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    push_zero(0, cyc + 1);
    push_zero(1, cyc + 1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Nominal 3x3 and asymmetric 3x2 runs launched together.
    base = cyc;
    push_run(0, base, 3, 12, 12, 21, 30, -1, 0, 1000);
    push_run(1, base, 2, 12, 8, 20, 26, -1, 0, 1000);
    start = 1'b1; start1 = 1'b1;
    tick();
    start = 1'b0; start1 = 1'b0;
    drain_wait();

    // Backpressure: three stall cycles on result (2,2).
    base = cyc;
    push_run(0, base, 3, 12, 12, 21, 33, 4, 3, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 25);
    out_ready = 1'b0;
    wait_to(base + 28);
    out_ready = 1'b1;
    drain_wait();

    // Start pulses while busy and in DONE are ignored; start in the next IDLE cycle launches.
    base = cyc;
    push_run(0, base, 3, 12, 12, 21, 30, -1, 0, 1000);
    push_run(0, base + 31, 3, 12, 12, 21, 30, -1, 0, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 30);
    start = 1'b1;
    wait_to(base + 32);
    start = 1'b0;
    drain_wait();

    // Reset during CALC, then a full run.
    base = cyc;
    push_run(0, base, 3, 12, 12, 21, 30, -1, 0, 15);
    push_zero(0, base + 16);
    push_run(0, base + 17, 3, 12, 12, 21, 30, -1, 0, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_to(base + 17);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain_wait();

`ifdef RSA_SEQ_ABORT_EN
    // Abort during DRAIN, then start together with abort in IDLE.
    base = cyc;
    push_run(0, base, 3, 12, 12, 21, 30, -1, 0, 23);
    push_zero(0, base + 24);
    push_zero(0, base + 27);
    push_zero(0, base + 28);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 23);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_to(base + 26);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    drain_wait();
`endif

    end_req = 1'b1;
  end

endmodule
